// File: rtl/mbist_mem_pkg.sv
// Shared definitions for the MBIST-wrapped memory slice.
//   DEFAULT_ADDR_W / DEFAULT_DATA_W : default geometry (8 words x 8 bits)
//   DEPTH                           : word count for the default geometry
//   TEST_MODE_MBIST / TEST_MODE_CPU : encodings of the test_mode select
package mbist_mem_pkg;

    localparam int unsigned DEFAULT_ADDR_W = 3;
    localparam int unsigned DEFAULT_DATA_W = 8;
    localparam int unsigned DEPTH          = 2 ** DEFAULT_ADDR_W;

    localparam logic TEST_MODE_MBIST = 1'b1;
    localparam logic TEST_MODE_CPU   = 1'b0;

endpackage : mbist_mem_pkg

// File: rtl/mbist_mem_array.sv
// Clocked single-port storage with asynchronous clear.
//   clk   : rising-edge clock
//   rst_n : async active-low reset; clears every word and dout
//   write : store din at addr on the rising edge
//   read  : load dout from addr on the rising edge (1-cycle latency)
//   din   : write data
//   addr  : word address (all 2**ADDR_W values valid)
//   dout  : registered read data, holds when read=0
module mbist_mem_array
    import mbist_mem_pkg::*;
#(
    parameter int unsigned ADDR_W = DEFAULT_ADDR_W,
    parameter int unsigned DATA_W = DEFAULT_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              write,
    input  logic              read,
    input  logic [DATA_W-1:0] din,
    input  logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] dout
);

    localparam int unsigned WORDS = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem_q [WORDS];
    logic [DATA_W-1:0] dout_q;
    logic [DATA_W-1:0] dout_d;

    // Read samples the pre-edge contents, so a same-address read and
    // write on one edge returns the old word (read-before-write).
    always_comb begin
        dout_d = dout_q;
        if (read) begin
            dout_d = mem_q[addr];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < WORDS; i++) begin
                mem_q[i] <= '0;
            end
            dout_q <= '0;
        end else begin
            dout_q <= dout_d;
            if (write) begin
                mem_q[addr] <= din;
            end
        end
    end

    assign dout = dout_q;

endmodule : mbist_mem_array

// File: rtl/mbist_mem_wrapper.sv
// Memory wrapper selecting between MBIST and CPU access ports.
//   clk, rst_n                          : clock, async active-low reset
//   test_mode                           : 1 = MBIST owns the array, 0 = CPU
//   mbist_rd/wr/addr/din                : MBIST access port
//   cpu_rd/wr/addr/din                  : functional CPU access port
//   mem_read/write/addr/din             : muxed controls seen by the array
//   dout                                : shared registered read data
module mbist_mem_wrapper
    import mbist_mem_pkg::*;
#(
    parameter int unsigned ADDR_W = DEFAULT_ADDR_W,
    parameter int unsigned DATA_W = DEFAULT_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              test_mode,
    input  logic              mbist_rd,
    input  logic              mbist_wr,
    input  logic [ADDR_W-1:0] mbist_addr,
    input  logic [DATA_W-1:0] mbist_din,
    input  logic              cpu_rd,
    input  logic              cpu_wr,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_din,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din,
    output logic [DATA_W-1:0] dout
);

    always_comb begin
        mem_read  = cpu_rd;
        mem_write = cpu_wr;
        mem_addr  = cpu_addr;
        mem_din   = cpu_din;
        if (test_mode == TEST_MODE_MBIST) begin
            mem_read  = mbist_rd;
            mem_write = mbist_wr;
            mem_addr  = mbist_addr;
            mem_din   = mbist_din;
        end
    end

    mbist_mem_array #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_array (
        .clk   (clk),
        .rst_n (rst_n),
        .write (mem_write),
        .read  (mem_read),
        .din   (mem_din),
        .addr  (mem_addr),
        .dout  (dout)
    );

endmodule : mbist_mem_wrapper

// File: tb/tb_mbist_mem_wrapper.sv
module tb_mbist_mem_wrapper;

    localparam int unsigned AW = 3;
    localparam int unsigned DW = 8;
    localparam int unsigned NW = 8;

    logic          clk;
    logic          rst_n;
    logic          test_mode;
    logic          mbist_rd, mbist_wr;
    logic [AW-1:0] mbist_addr;
    logic [DW-1:0] mbist_din;
    logic          cpu_rd, cpu_wr;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_din;
    logic          mem_read, mem_write;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_din;
    logic [DW-1:0] dout;

    int checks   = 0;
    int failures = 0;

    // Reference: a plain byte array plus the last value returned on dout.
    logic [DW-1:0] ref_mem [NW];
    logic [DW-1:0] ref_dout;

    mbist_mem_wrapper #(
        .ADDR_W (AW),
        .DATA_W (DW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .test_mode  (test_mode),
        .mbist_rd   (mbist_rd),
        .mbist_wr   (mbist_wr),
        .mbist_addr (mbist_addr),
        .mbist_din  (mbist_din),
        .cpu_rd     (cpu_rd),
        .cpu_wr     (cpu_wr),
        .cpu_addr   (cpu_addr),
        .cpu_din    (cpu_din),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_addr   (mem_addr),
        .mem_din    (mem_din),
        .dout       (dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic drive(input logic tm,
                         input logic mrd, input logic mwr, input logic [AW-1:0] ma, input logic [DW-1:0] md,
                         input logic crd, input logic cwr, input logic [AW-1:0] ca, input logic [DW-1:0] cd);
        test_mode  = tm;
        mbist_rd   = mrd;  mbist_wr = mwr;  mbist_addr = ma;  mbist_din = md;
        cpu_rd     = crd;  cpu_wr   = cwr;  cpu_addr   = ca;  cpu_din   = cd;
    endtask

    task automatic ref_clear();
        for (int i = 0; i < NW; i++) ref_mem[i] = '0;
        ref_dout = '0;
    endtask

    // Called at a negedge with inputs already driven: checks the mux,
    // advances one clock through the reference, then checks dout.
    task automatic step();
        logic          e_rd, e_wr;
        logic [AW-1:0] e_a;
        logic [DW-1:0] e_d, old_word;
        #1;
        e_rd = test_mode ? mbist_rd   : cpu_rd;
        e_wr = test_mode ? mbist_wr   : cpu_wr;
        e_a  = test_mode ? mbist_addr : cpu_addr;
        e_d  = test_mode ? mbist_din  : cpu_din;
        check_eq("mux_read",  32'(mem_read),  32'(e_rd));
        check_eq("mux_write", 32'(mem_write), 32'(e_wr));
        check_eq("mux_addr",  32'(mem_addr),  32'(e_a));
        check_eq("mux_din",   32'(mem_din),   32'(e_d));
        @(posedge clk);
        if (rst_n) begin
            old_word = ref_mem[e_a];
            if (e_wr) ref_mem[e_a] = e_d;
            if (e_rd) ref_dout = old_word;
        end
        @(negedge clk);
        check_eq("dout", 32'(dout), 32'(ref_dout));
    endtask

    // Async reset asserted mid-cycle; held across one edge with a write
    // request active to show the write is blocked.
    task automatic reset_pulse();
        #2 rst_n = 1'b0;
        #1 check_eq("async_rst_dout", 32'(dout), 32'h0);
        ref_clear();
        drive(1'b1, 1'b1, 1'b1, AW'($urandom), DW'($urandom) | 8'h01,
              1'b1, 1'b1, AW'($urandom), DW'($urandom) | 8'h01);
        @(negedge clk);
        step();
        rst_n = 1'b1;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        ref_clear();
        #2;
        check_eq("rst_dout_initial", 32'(dout), 32'h0);
        @(negedge clk);
        step();
        rst_n = 1'b1;

        // Arbitrary writes, then reset, then read all words in both modes.
        for (int i = 0; i < 8; i++) begin
            drive(1'($urandom), 1'b0, 1'b1, AW'($urandom), DW'($urandom),
                  1'b0, 1'b1, AW'($urandom), DW'($urandom));
            step();
        end
        reset_pulse();
        for (int m = 0; m < 2; m++) begin
            for (int a = 0; a < NW; a++) begin
                drive(1'(m), 1'b1, 1'b0, AW'(a), 8'hEE, 1'b1, 1'b0, AW'(a), 8'hEE);
                step();
                check_eq("post_rst_zero", 32'(dout), 32'h0);
            end
        end

        // MBIST ownership with a competing CPU write.
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 1'b0, 1'b1, 3'd2, 8'hFF, 1'b0, 1'b1, 3'd4, 8'hDD);
            step();
        end
        drive(1'b1, 1'b1, 1'b0, 3'd4, 8'h00, 1'b0, 1'b0, 3'd0, 8'h00);
        step();
        check_eq("mem4_untouched", 32'(dout), 32'h00);

        // CPU ownership: read addr 2 while MBIST requests addr 4.
        drive(1'b0, 1'b1, 1'b0, 3'd4, 8'hCC, 1'b1, 1'b0, 3'd2, 8'h00);
        step();
        check_eq("cpu_rd_mem2", 32'(dout), 32'hFF);

        // CPU write/readback, then MBIST readback.
        drive(1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 1'b1, 3'd5, 8'hA5);
        step();
        drive(1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 1'b1, 1'b0, 3'd5, 8'h00);
        step();
        check_eq("cpu_rb_5", 32'(dout), 32'hA5);
        drive(1'b1, 1'b1, 1'b0, 3'd5, 8'h00, 1'b0, 1'b0, 3'd0, 8'h00);
        step();
        check_eq("mbist_rb_5", 32'(dout), 32'hA5);

        // Read-before-write at one address.
        drive(1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 1'b1, 3'd3, 8'h11);
        step();
        drive(1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 1'b1, 1'b1, 3'd3, 8'h22);
        step();
        check_eq("rbw_old", 32'(dout), 32'h11);
        drive(1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 1'b1, 1'b0, 3'd3, 8'h00);
        step();
        check_eq("rbw_new", 32'(dout), 32'h22);

        // Hold, then async reset mid-cycle.
        drive(1'b1, 1'b1, 1'b0, 3'd2, 8'h00, 1'b0, 1'b0, 3'd0, 8'h00);
        step();
        idle();
        for (int i = 0; i < 3; i++) begin
            step();
            check_eq("hold_ff", 32'(dout), 32'hFF);
        end
        reset_pulse();

        // Randomized traffic with occasional async resets.
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom), 1'($urandom), 1'($urandom), AW'($urandom), DW'($urandom),
                  1'($urandom), 1'($urandom), AW'($urandom), DW'($urandom));
            if ($urandom_range(0, 59) == 0) reset_pulse();
            else step();
        end

        // Final sweep of every word against the reference.
        for (int a = 0; a < NW; a++) begin
            drive(1'b1, 1'b1, 1'b0, AW'(a), 8'h00, 1'b0, 1'b0, 3'd0, 8'h00);
            step();
            check_eq("sweep", 32'(dout), 32'(ref_mem[a]));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_mbist_mem_wrapper
